// File: rtl/tug_pkg.sv
// Shared types for the tug-of-war playfield: round winner encoding and FSM states.
package tug_pkg;

   typedef enum logic [1:0] {
      WIN_NONE  = 2'd0,
      WIN_LEFT  = 2'd1,
      WIN_RIGHT = 2'd2
   } winner_t;

   typedef enum logic {
      ST_PLAY = 1'b0,
      ST_WON  = 1'b1
   } tug_state_t;

endpackage

// File: rtl/tug_score_counter.sv
// Saturating per-player round counter; holds at all-ones once full.
module tug_score_counter #(
   parameter int SCORE_W = 3
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               inc,
   output logic [SCORE_W-1:0] count
);

   localparam logic [SCORE_W-1:0] MAX_COUNT = '1;

   logic [SCORE_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (Reset)
         r_count <= '0;
      else if (inc && (r_count != MAX_COUNT))
         r_count <= r_count + 1'b1;
   end

   assign count = r_count;

endmodule

// File: rtl/tug_track.sv
// Tug-of-war playfield: one lit lamp walked by L/R presses, round FSM and scores.
// Optional auto-restart after HOLD_CYCLES in WON is enabled by defining TUG_AUTO_RESTART_EN.
module tug_track
   import tug_pkg::*;
#(
   parameter int NUM_LIGHTS  = 9,
   parameter int SCORE_W     = 3,
   parameter int HOLD_CYCLES = 50
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  L,
   input  logic                  R,
   input  logic                  restart,
   output logic [NUM_LIGHTS-1:0] lights,
   output logic [1:0]            winner,
   output logic [SCORE_W-1:0]    left_score,
   output logic [SCORE_W-1:0]    right_score
);

   localparam int POS_W = $clog2(NUM_LIGHTS);
   localparam logic [POS_W-1:0] CENTRE = POS_W'((NUM_LIGHTS - 1) / 2);
   localparam logic [POS_W-1:0] LAST   = POS_W'(NUM_LIGHTS - 1);

   generate
      if ((NUM_LIGHTS < 3) || ((NUM_LIGHTS % 2) == 0) || (HOLD_CYCLES < 1)) begin : g_badParams
         $error("tug_track: NUM_LIGHTS must be odd and >= 3, HOLD_CYCLES >= 1");
      end
   endgenerate

   tug_state_t            r_state;
   tug_state_t            w_stateNext;
   logic [POS_W-1:0]      r_pos;
   logic [POS_W-1:0]      w_posNext;
   winner_t               r_winner;
   winner_t               w_winnerNext;
   logic [NUM_LIGHTS-1:0] r_lights;
   logic [NUM_LIGHTS-1:0] w_lightsNext;
   logic                  w_incLeft;
   logic                  w_incRight;

`ifdef TUG_AUTO_RESTART_EN
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_holdNext;
`endif

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state  <= ST_PLAY;
         r_pos    <= CENTRE;
         r_winner <= WIN_NONE;
         r_lights <= NUM_LIGHTS'(1) << CENTRE;
`ifdef TUG_AUTO_RESTART_EN
         r_hold   <= '0;
`endif
      end else begin
         r_state  <= w_stateNext;
         r_pos    <= w_posNext;
         r_winner <= w_winnerNext;
         r_lights <= w_lightsNext;
`ifdef TUG_AUTO_RESTART_EN
         r_hold   <= w_holdNext;
`endif
      end
   end

   // A tie (L and R together) is treated the same as no press at all.
   always_comb begin
      w_stateNext  = r_state;
      w_posNext    = r_pos;
      w_winnerNext = r_winner;
      w_incLeft    = 1'b0;
      w_incRight   = 1'b0;
`ifdef TUG_AUTO_RESTART_EN
      w_holdNext   = '0;
`endif

      case (r_state)
         ST_PLAY: begin
            if (L && !R) begin
               if (r_pos == LAST) begin
                  w_stateNext  = ST_WON;
                  w_winnerNext = WIN_LEFT;
                  w_incLeft    = 1'b1;
               end else begin
                  w_posNext = r_pos + 1'b1;
               end
            end else if (R && !L) begin
               if (r_pos == '0) begin
                  w_stateNext  = ST_WON;
                  w_winnerNext = WIN_RIGHT;
                  w_incRight   = 1'b1;
               end else begin
                  w_posNext = r_pos - 1'b1;
               end
            end
         end

         ST_WON: begin
            if (restart) begin
               w_stateNext  = ST_PLAY;
               w_posNext    = CENTRE;
               w_winnerNext = WIN_NONE;
            end
`ifdef TUG_AUTO_RESTART_EN
            else if (r_hold == HOLD_LAST) begin
               w_stateNext  = ST_PLAY;
               w_posNext    = CENTRE;
               w_winnerNext = WIN_NONE;
            end else begin
               w_holdNext = r_hold + 1'b1;
            end
`endif
         end

         default: begin
            w_stateNext  = ST_PLAY;
            w_posNext    = CENTRE;
            w_winnerNext = WIN_NONE;
         end
      endcase

      w_lightsNext = (w_stateNext == ST_PLAY) ? (NUM_LIGHTS'(1) << w_posNext) : '0;
   end

   tug_score_counter #(
      .SCORE_W (SCORE_W)
   ) u_leftScore (
      .clk   (clk),
      .Reset (Reset),
      .inc   (w_incLeft),
      .count (left_score)
   );

   tug_score_counter #(
      .SCORE_W (SCORE_W)
   ) u_rightScore (
      .clk   (clk),
      .Reset (Reset),
      .inc   (w_incRight),
      .count (right_score)
   );

   assign lights = r_lights;
   assign winner = r_winner;

endmodule

// File: tb/tb_tug_track.sv
// Directed bench for tug_track with a 5-lamp field, 2-bit scores and a 4-cycle hold.
// Covers the TUG_AUTO_RESTART_EN build as well when that macro is defined.
module tb_tug_track;

   localparam int NL = 5;
   localparam int SW = 2;
   localparam int HC = 4;

   logic          clk = 1'b0;
   logic          Reset = 1'b0;
   logic          L = 1'b0;
   logic          R = 1'b0;
   logic          restart = 1'b0;
   logic [NL-1:0] lights;
   logic [1:0]    winner;
   logic [SW-1:0] left_score;
   logic [SW-1:0] right_score;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic          l;
      logic          r;
      logic          rs;
      logic [NL-1:0] expLights;
      logic [1:0]    expWinner;
      logic [SW-1:0] expLeft;
      logic [SW-1:0] expRight;
   } vec_t;

   vec_t vecs [0:30];

   tug_track #(
      .NUM_LIGHTS  (NL),
      .SCORE_W     (SW),
      .HOLD_CYCLES (HC)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .L           (L),
      .R           (R),
      .restart     (restart),
      .lights      (lights),
      .winner      (winner),
      .left_score  (left_score),
      .right_score (right_score)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge, release them just after the rising edge.
   task automatic applyStimulus(input logic l, input logic r, input logic rs);
      @(negedge clk);
      L       = l;
      R       = r;
      restart = rs;
      @(posedge clk);
      #1;
      L       = 1'b0;
      R       = 1'b0;
      restart = 1'b0;
   endtask

   task automatic applyReset(input int n, input logic l);
      @(negedge clk);
      Reset = 1'b1;
      L     = l;
      repeat (n) @(posedge clk);
      #1;
      Reset = 1'b0;
      L     = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [NL-1:0] eLights, input logic [1:0] eWinner,
                              input logic [SW-1:0] eLeft, input logic [SW-1:0] eRight);
      checks++;
      if (lights !== eLights || winner !== eWinner || left_score !== eLeft || right_score !== eRight) begin
         errors++;
         $display("[TB] FAIL %s: got lights=%b winner=%0d scores=%0d/%0d, want lights=%b winner=%0d scores=%0d/%0d",
                  name, lights, winner, left_score, right_score, eLights, eWinner, eLeft, eRight);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'b00100, 2'd0, 2'd0, 2'd0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 5'b01000, 2'd0, 2'd0, 2'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'b10000, 2'd0, 2'd0, 2'd0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 2'd1, 2'd1, 2'd0};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'b00000, 2'd1, 2'd1, 2'd0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'b00000, 2'd1, 2'd1, 2'd0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'b00100, 2'd0, 2'd1, 2'd0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'b00100, 2'd0, 2'd1, 2'd0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 5'b00100, 2'd0, 2'd1, 2'd0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 5'b00100, 2'd0, 2'd1, 2'd0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 5'b00100, 2'd0, 2'd1, 2'd0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 5'b00010, 2'd0, 2'd1, 2'd0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 5'b00001, 2'd0, 2'd1, 2'd0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 5'b00000, 2'd2, 2'd1, 2'd1};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 5'b00100, 2'd0, 2'd1, 2'd1};
      vecs[15] = '{1'b0, 1'b1, 1'b0, 5'b00010, 2'd0, 2'd1, 2'd1};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 5'b00001, 2'd0, 2'd1, 2'd1};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 5'b00000, 2'd2, 2'd1, 2'd2};
      vecs[18] = '{1'b0, 1'b0, 1'b1, 5'b00100, 2'd0, 2'd1, 2'd2};
      vecs[19] = '{1'b0, 1'b1, 1'b0, 5'b00010, 2'd0, 2'd1, 2'd2};
      vecs[20] = '{1'b0, 1'b1, 1'b0, 5'b00001, 2'd0, 2'd1, 2'd2};
      vecs[21] = '{1'b0, 1'b1, 1'b0, 5'b00000, 2'd2, 2'd1, 2'd3};
      vecs[22] = '{1'b0, 1'b0, 1'b1, 5'b00100, 2'd0, 2'd1, 2'd3};
      vecs[23] = '{1'b0, 1'b1, 1'b0, 5'b00010, 2'd0, 2'd1, 2'd3};
      vecs[24] = '{1'b0, 1'b1, 1'b0, 5'b00001, 2'd0, 2'd1, 2'd3};
      vecs[25] = '{1'b0, 1'b1, 1'b0, 5'b00000, 2'd2, 2'd1, 2'd3};
      vecs[26] = '{1'b0, 1'b0, 1'b1, 5'b00100, 2'd0, 2'd1, 2'd3};
      vecs[27] = '{1'b1, 1'b0, 1'b0, 5'b01000, 2'd0, 2'd1, 2'd3};
      vecs[28] = '{1'b1, 1'b1, 1'b0, 5'b01000, 2'd0, 2'd1, 2'd3};
      vecs[29] = '{1'b0, 1'b1, 1'b0, 5'b00100, 2'd0, 2'd1, 2'd3};
      vecs[30] = '{1'b1, 1'b0, 1'b1, 5'b01000, 2'd0, 2'd1, 2'd3};

      // Reset state, then idle stability.
      applyReset(2, 1'b0);
      checkOutput("reset", 5'b00100, 2'd0, 2'd0, 2'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("idle%0d", i), 5'b00100, 2'd0, 2'd0, 2'd0);
      end

      for (int i = 0; i < 31; i++) begin
         applyStimulus(vecs[i].l, vecs[i].r, vecs[i].rs);
         checkOutput($sformatf("vec%0d", i), vecs[i].expLights, vecs[i].expWinner,
                     vecs[i].expLeft, vecs[i].expRight);
      end

      // Build scores 2/1 with the lamp at 00010, then reset mid-round with L held.
      applyReset(1, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("preReset", 5'b00010, 2'd0, 2'd2, 2'd1);
      applyReset(1, 1'b1);
      checkOutput("midReset", 5'b00100, 2'd0, 2'd0, 2'd0);

      // Reset while in WON also clears scores.
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("wonBeforeReset", 5'b00000, 2'd1, 2'd1, 2'd0);
      applyReset(1, 1'b0);
      checkOutput("wonReset", 5'b00100, 2'd0, 2'd0, 2'd0);

      // Behaviour of WON with no restart.
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("holdEntry", 5'b00000, 2'd1, 2'd1, 2'd0);
`ifdef TUG_AUTO_RESTART_EN
      for (int i = 1; i < HC; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("hold%0d", i), 5'b00000, 2'd1, 2'd1, 2'd0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("autoRestart", 5'b00100, 2'd0, 2'd1, 2'd0);
`else
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("hold%0d", i), 5'b00000, 2'd1, 2'd1, 2'd0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("lateRestart", 5'b00100, 2'd0, 2'd1, 2'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
